// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: imem request/response, execute redirect, decode handshake, fault.
// Handshakes: a beat transfers on the rising edge where valid (req) and ready (gnt) are both high;
// a producer holds its payload stable while valid is high and ready is low.
interface fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ins_valid_o;
    logic        ins_ready_i;
    logic [31:0] ins_o;
    logic [31:0] ins_pc_o;
    logic        fault_o;

    modport master (
        output imem_req_o, imem_addr_o, ins_valid_o, ins_o, ins_pc_o, fault_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ins_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, ins_valid_o, ins_o, ins_pc_o, fault_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ins_ready_i
    );
endinterface

// File: rtl/fetch_fifo.sv
// Registered fetch queue of {insn, pc} entries; flush empties it on the same edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the head slot this edge, so a full queue may still accept a push.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, one-outstanding imem fetch FSM, fetch queue and redirect handling.
// Optional MISALIGN_CHECK_EN: a misaligned redirect target raises a sticky fault and halts fetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_if.master     bus,
    output logic [1:0]  o_dbg_state
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_HALT  = HALT;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          w_misalign;
    logic          w_redirect;
    logic          w_halt_now;
    logic          w_req;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;

`ifdef MISALIGN_CHECK_EN
    logic r_fault;
    assign w_misalign = bus.redirect_pc_i[1:0] != 2'b00;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_redirect  = bus.redirect_i && (r_state != ST_HALT);
    assign w_halt_now  = w_redirect && w_misalign;
    assign w_req       = rst_n && (r_state == ST_RUN) && (w_count < CW'(FQ_DEPTH)) && !bus.redirect_i;
    assign w_gnt       = w_req && bus.imem_gnt_i;
    // A redirect on the same edge beats both the push of a returning word and a decode pop.
    assign w_push      = (r_state == ST_WAIT) && bus.imem_rvalid_i && !w_redirect;
    assign w_valid     = rst_n && (w_count != '0);
    assign w_pop       = w_valid && bus.ins_ready_i && !w_redirect;
    assign w_push_data = '{insn: bus.imem_rdata_i, pc: r_req_pc};

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_gnt) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rvalid_i)  w_state_nxt = ST_RUN;
                else if (w_redirect)    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (bus.imem_rvalid_i) w_state_nxt = ST_RUN;
            default:  w_state_nxt = r_state;
        endcase
        if (w_halt_now) w_state_nxt = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect)  r_pc <= align_word(bus.redirect_pc_i);
            else if (w_gnt)  r_pc <= r_pc + 32'd4;
            if (w_gnt)       r_req_pc <= r_pc;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          r_fault <= 1'b0;
        else if (w_halt_now) r_fault <= 1'b1;
    end
    assign bus.fault_o = r_fault;
`else
    assign bus.fault_o = 1'b0;
`endif

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_pc;
    assign bus.ins_valid_o = w_valid;
    assign bus.ins_o       = w_valid ? w_head.insn : INSN_NOP;
    assign bus.ins_pc_o    = w_valid ? w_head.pc : 32'h0;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random imem responder, random decode backpressure and redirects,
// checked against an in-order PC-stream model through an expected-entry queue.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    fetch_if bus();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- counters / checker ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // ---------------- reference model ----------------
    // The architectural stream is RESET_PC, +4, +4 ... restarted at every redirect target.
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    bit          model_halt = 0;
    bit          exp_addr_pending = 0;
    logic [31:0] exp_addr;

    task automatic model_top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back({mem_word(model_pc), model_pc});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        model_pc         = {target[31:2], 2'b00};
        exp_addr         = model_pc;
        exp_addr_pending = 1;
        model_top_up();
    endtask

    // ---------------- imem responder ----------------
    int          gnt_pct = 100;
    int          rv_min = 1;
    int          rv_max = 1;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mem_word(pend_addr);
                    pend = 0;
                end
            end
            bus.imem_gnt_i = ($urandom_range(99) < gnt_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          n_xfer = 0;
    int          pop_cnt = 0;
    int          first_gnt_cyc = -1;
    int          first_valid_cyc = -1;
    bit          prev_hold = 0;
    logic [31:0] prev_ins, prev_pc;
    logic [63:0] e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!bus.ins_valid_o) chk("nop_when_idle", bus.ins_o, INSN_NOP);
            if (rst_n) begin
                if (prev_hold) begin
                    chk("hold_ins", bus.ins_o, prev_ins);
                    chk("hold_pc", bus.ins_pc_o, prev_pc);
                end
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    n_xfer++;
                    if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                    chk("one_outstanding", {31'b0, pend}, 32'd0);
                    if (exp_addr_pending) begin
                        chk("restart_addr", bus.imem_addr_o, exp_addr);
                        exp_addr_pending = 0;
                    end
                    pend      = 1;
                    pend_cnt  = $urandom_range(rv_max, rv_min);
                    pend_addr = bus.imem_addr_o;
                end
                if (bus.ins_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.ins_valid_o && bus.ins_ready_i && !bus.redirect_i) begin
                    pop_cnt++;
                    if (model_halt) begin
                        chk("pop_while_halted", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        model_top_up();
                        chk("ins_pc", bus.ins_pc_o, e[31:0]);
                        chk("ins_word", bus.ins_o, e[63:32]);
                    end
                end
            end
            prev_hold = rst_n && bus.ins_valid_o && !bus.ins_ready_i && !bus.redirect_i;
            prev_ins  = bus.ins_o;
            prev_pc   = bus.ins_pc_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cycles(1);
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, bus.ins_valid_o}, 32'd0);
        chk("rst_ins", bus.ins_o, INSN_NOP);
        chk("rst_ins_pc", bus.ins_pc_o, 32'd0);
        chk("rst_fault", {31'b0, bus.fault_o}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'(RUN));
        cycles(n - 1);
        model_halt      = 0;
        model_restart(RESET_PC);
        pend            = 0;
        first_gnt_cyc   = -1;
        first_valid_cyc = -1;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = target;
        model_restart(target);
        cycles(1);
        bus.redirect_i    = 1'b0;
    endtask

    task automatic wait_xfer();
        int n0 = n_xfer;
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cycles(1);
            if (n_xfer != n0) seen = 1;
        end
        chk("xfer_wait", {31'b0, seen}, 32'd1);
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] held_ins, held_pc, tgt;
    int          n0, p0;

    initial begin
        bus.ins_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;

        // streaming, minimum latency
        bus.ins_ready_i = 1'b1;
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        do_reset(3);
        cycles(12);
        chk("first_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
        chk("stream_progress", {31'b0, pop_cnt >= 3}, 32'd1);

        // backpressure fills the queue then stops requesting
        bus.ins_ready_i = 1'b0;
        cycles(6);
        held_ins = bus.ins_o;
        held_pc  = bus.ins_pc_o;
        n0 = n_xfer;
        gnt_pct = 0;
        cycles(3);
        chk("bp_req_off", {31'b0, bus.imem_req_o}, 32'd0);
        chk("bp_valid", {31'b0, bus.ins_valid_o}, 32'd1);
        chk("bp_ins_held", bus.ins_o, held_ins);
        chk("bp_head_pc", bus.ins_pc_o, exp_q[0][31:0]);
        chk("bp_no_xfer", 32'(n_xfer - n0), 32'd0);
        p0 = pop_cnt;
        bus.ins_ready_i = 1'b1;
        cycles(6);
        chk("bp_buffered", 32'(pop_cnt - p0), 32'(FQ_DEPTH));

        // redirect while waiting on a slow response
        bus.ins_ready_i = 1'b0;
        gnt_pct = 100; rv_min = 3; rv_max = 3;
        wait_xfer();
        gnt_pct = 0;
        redirect(32'h0000_0100);
        chk("wait_redirect_state", {30'b0, dbg_state}, 32'(DRAIN));
        chk("drain_req_off", {31'b0, bus.imem_req_o}, 32'd0);
        cycles(2);
        chk("late_word_dropped", {31'b0, bus.ins_valid_o}, 32'd0);
        bus.ins_ready_i = 1'b1;
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        cycles(10);

        // redirect in the same cycle as rvalid and ready
        rv_min = 2; rv_max = 2;
        wait_xfer();
        gnt_pct = 0;
        cycles(1);
        redirect(32'h0000_0200);
        chk("rv_redirect_empty", {31'b0, bus.ins_valid_o}, 32'd0);
        chk("rv_redirect_state", {30'b0, dbg_state}, 32'(RUN));
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        cycles(10);

        // misaligned redirect
`ifdef MISALIGN_CHECK_EN
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0102;
        model_halt        = 1;
        exp_q.delete();
        exp_addr_pending  = 0;
        cycles(1);
        bus.redirect_i    = 1'b0;
        n0 = n_xfer;
        chk("halt_fault", {31'b0, bus.fault_o}, 32'd1);
        chk("halt_state", {30'b0, dbg_state}, 32'(HALT));
        cycles(10);
        chk("halt_no_req", 32'(n_xfer - n0), 32'd0);
        chk("halt_req_low", {31'b0, bus.imem_req_o}, 32'd0);
        chk("halt_valid_low", {31'b0, bus.ins_valid_o}, 32'd0);
        chk("halt_fault_sticky", {31'b0, bus.fault_o}, 32'd1);
        do_reset(1);
        cycles(10);
`else
        redirect(32'h0000_0102);
        cycles(10);
        chk("misalign_no_fault", {31'b0, bus.fault_o}, 32'd0);
`endif

        // reset while a request is outstanding; the late rvalid lands inside reset
        rv_min = 2; rv_max = 2;
        wait_xfer();
        do_reset(3);
        rv_min = 1; rv_max = 3;
        cycles(10);

        // PC wraps modulo 2^32
        redirect(32'hFFFF_FFF4);
        cycles(16);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 20 == 0) gnt_pct = $urandom_range(100, 30);
            bus.ins_ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) begin
                tgt = $urandom;
`ifdef MISALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                redirect(tgt);
            end else begin
                cycles(1);
            end
        end

        bus.ins_ready_i = 1'b1;
        gnt_pct = 0;
        cycles(12);
        chk("final_pops_seen", {31'b0, pop_cnt > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end
endmodule
